// File: rtl/adder_arbiter.sv
// Two-requester arbiter in front of a single shared ripple-carry adder.
// Round-robin grant on conflict, one result held until the consumer takes it.

module ripple_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);

  logic [WIDTH:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  // Signed overflow: carry into the MSB differs from carry out of it.
  assign overflow = carry[WIDTH] ^ carry[WIDTH-1];

endmodule

module adder_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_overflow,
  output logic             rsp_id
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             last_grant;
  logic             grant_id;
  logic             accept;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      op_cin     <= 1'b0;
      rsp_id     <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= next_state;
      if (accept) begin
        op_a       <= grant_id ? req1_a   : req0_a;
        op_b       <= grant_id ? req1_b   : req0_b;
        op_cin     <= grant_id ? req1_cin : req0_cin;
        rsp_id     <= grant_id;
        last_grant <= grant_id;
      end
    end
  end

  // Ready is gated by reset_n so both requesters see ready low throughout reset.
  always_comb begin
    next_state = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    grant_id   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    case (state)
      IDLE: begin
        accept     = (req0_valid || req1_valid) && reset_n;
        req0_ready = accept && !grant_id;
        req1_ready = accept && grant_id;
        if (accept) next_state = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  ripple_adder #(.WIDTH(WIDTH)) u_adder (
    .a        (op_a),
    .b        (op_b),
    .cin      (op_cin),
    .sum      (rsp_sum),
    .overflow (rsp_overflow)
  );

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized and directed check of adder_arbiter against a transaction-level model.

module tb_adder_arbiter;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req0_valid, req1_valid, req0_cin, req1_cin;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic         rsp_valid, rsp_ready, rsp_overflow, rsp_id;
  logic [W-1:0] rsp_sum;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model: one pending result or none, plus last granted id.
  bit           m_pending;
  bit [W-1:0]   m_sum;
  bit           m_ovf;
  bit           m_id;
  bit           m_last;

  adder_arbiter #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req0_valid   (req0_valid),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_cin     (req0_cin),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_cin     (req1_cin),
    .req1_ready   (req1_ready),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_sum      (rsp_sum),
    .rsp_overflow (rsp_overflow),
    .rsp_id       (rsp_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pending = 1'b0;
    m_sum     = '0;
    m_ovf     = 1'b0;
    m_id      = 1'b0;
    m_last    = 1'b1;
  endtask

  // One clock cycle: drive inputs after the falling edge, check, advance the model.
  task automatic step(input bit v0, input bit [W-1:0] a0, input bit [W-1:0] b0, input bit c0,
                      input bit v1, input bit [W-1:0] a1, input bit [W-1:0] b1, input bit c1,
                      input bit rr);
    bit          has_grant;
    bit          g;
    int unsigned total;
    bit [W-1:0]  sa, sb;
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1;
    rsp_ready  = rr;
    #1;
    has_grant = !m_pending && (v0 || v1);
    if (v0 && v1) g = !m_last;
    else          g = v1;
    check("req0_ready", req0_ready, has_grant && !g);
    check("req1_ready", req1_ready, has_grant && g);
    check("rsp_valid", rsp_valid, m_pending);
    if (m_pending) begin
      check("rsp_sum", rsp_sum, m_sum);
      check("rsp_overflow", rsp_overflow, m_ovf);
      check("rsp_id", rsp_id, m_id);
    end
    if (m_pending) begin
      if (rr) m_pending = 1'b0;
    end else if (has_grant) begin
      sa        = g ? a1 : a0;
      sb        = g ? b1 : b0;
      total     = int'(sa) + int'(sb) + int'(g ? c1 : c0);
      m_sum     = total[W-1:0];
      m_ovf     = (sa[W-1] == sb[W-1]) && (m_sum[W-1] != sa[W-1]);
      m_id      = g;
      m_last    = g;
      m_pending = 1'b1;
    end
  endtask

  task automatic idle(input bit rr);
    step(0, '0, '0, 0, 0, '0, '0, 0, rr);
  endtask

  initial begin
    reset_n = 1'b0;
    req0_valid = 1'b1; req0_a = 8'hAA; req0_b = 8'h55; req0_cin = 1'b1;
    req1_valid = 1'b1; req1_a = 8'h11; req1_b = 8'h22; req1_cin = 1'b0;
    rsp_ready  = 1'b0;
    model_reset();
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_sum", rsp_sum, 0);
    check("rst_rsp_ovf", rsp_overflow, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    repeat (2) @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset_n    = 1'b1;

    // Conflict straight after reset: req0 first, then alternation.
    step(1, 8'h05, 8'h03, 0, 1, 8'h7F, 8'h01, 0, 1);
    check("c_first_grant0", req0_ready, 1);
    step(1, 8'h05, 8'h03, 0, 1, 8'h7F, 8'h01, 0, 1);
    check("c_sum0", rsp_sum, 8'h08);
    check("c_ovf0", rsp_overflow, 0);
    check("c_id0", rsp_id, 0);
    step(1, 8'h05, 8'h03, 0, 1, 8'h7F, 8'h01, 0, 1);
    check("c_second_grant1", req1_ready, 1);
    step(1, 8'h05, 8'h03, 0, 1, 8'h7F, 8'h01, 0, 1);
    check("c_sum1", rsp_sum, 8'h80);
    check("c_ovf1", rsp_overflow, 1);
    check("c_id1", rsp_id, 1);
    for (int i = 0; i < 16; i++) begin
      step(1, 8'($urandom), 8'($urandom), 1'($urandom), 1, 8'($urandom), 8'($urandom), 1'($urandom), 1);
      if (i % 4 == 0) check("alt_grant0", req0_ready, 1);
      if (i % 4 == 2) check("alt_grant1", req1_ready, 1);
    end

    // Single requester 0.
    step(1, 8'h12, 8'h34, 0, 0, '0, '0, 0, 0);
    check("s_ready0", req0_ready, 1);
    idle(1);
    check("s_sum", rsp_sum, 8'h46);
    check("s_ovf", rsp_overflow, 0);
    check("s_id", rsp_id, 0);

    // Wrap-around on requester 1.
    step(0, '0, '0, 0, 1, 8'hFF, 8'h01, 1, 0);
    idle(1);
    check("w_sum", rsp_sum, 8'h01);
    check("w_ovf", rsp_overflow, 0);
    check("w_id", rsp_id, 1);

    // Negative overflow to zero.
    step(1, 8'h80, 8'h80, 0, 0, '0, '0, 0, 0);
    idle(1);
    check("n_sum", rsp_sum, 8'h00);
    check("n_ovf", rsp_overflow, 1);

    // Backpressure: result held, requests ignored, one accept after release.
    step(1, 8'h21, 8'h43, 1, 0, '0, '0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 8'($urandom), 8'($urandom), 0, 1, 8'($urandom), 8'($urandom), 1, 0);
      check("bp_sum", rsp_sum, 8'h65);
      check("bp_ready_low", {req0_ready, req1_ready}, 2'b00);
    end
    step(1, 8'h01, 8'h01, 0, 1, 8'h02, 8'h02, 0, 1);
    step(1, 8'h01, 8'h01, 0, 1, 8'h02, 8'h02, 0, 0);
    step(1, 8'h01, 8'h01, 0, 1, 8'h02, 8'h02, 0, 1);

    // Asynchronous reset while a result is held.
    step(1, 8'h33, 8'h44, 0, 0, '0, '0, 0, 0);
    idle(0);
    check("pre_rst_valid", rsp_valid, 1);
    @(negedge clk);
    #2;
    reset_n    = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("ar_rsp_valid", rsp_valid, 0);
    check("ar_rsp_sum", rsp_sum, 0);
    check("ar_rsp_ovf", rsp_overflow, 0);
    check("ar_rsp_id", rsp_id, 0);
    check("ar_ready", {req0_ready, req1_ready}, 2'b00);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    reset_n = 1'b1;
    model_reset();
    step(1, 8'h09, 8'h09, 0, 1, 8'h0A, 8'h0A, 0, 1);
    check("ar_conflict_grant0", req0_ready, 1);
    idle(1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, 8'($urandom), 8'($urandom), 1'($urandom),
           $urandom_range(0, 9) < 7, 8'($urandom), 8'($urandom), 1'($urandom),
           $urandom_range(0, 9) < 6);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
